// File: rtl/maze_pkg.sv
// Shared types for the maze DFS solver: direction codes, FSM states, cell coordinates.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INIT   = 4'd1,
    S_INITW  = 4'd2,
    S_CHECK  = 4'd3,
    S_WAIT   = 4'd4,
    S_BACK   = 4'd5,
    S_REPLAY = 4'd6,
    S_DONE   = 4'd7,
    S_FAIL   = 4'd8
  } state_e;

  // One spare bit above the largest N, so a step off either edge lands outside 0..N-1.
  localparam int MAX_CW = 7;

  typedef struct packed {
    logic [MAX_CW-1:0] y;
    logic [MAX_CW-1:0] x;
  } coord_t;

endpackage

// File: rtl/maze_path_stack.sv
// LIFO of {y, x, dir} entries with top-dir rewrite and an indexed read port.
module maze_path_stack #(
  parameter int CW    = 3,
  parameter int DEPTH = 64,
  parameter int SPW   = $clog2(DEPTH + 1),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic              wr_top,
  input  logic [2*CW+2:0]   push_data,
  input  logic [2:0]        top_dir,
  input  logic [AW-1:0]     rd_idx,
  output logic [2*CW+2:0]   rd_data,
  output logic [SPW-1:0]    sp,
  output logic              full,
  output logic              empty
);

  logic [2*CW+2:0] mem_r [0:(1<<AW)-1];
  logic [SPW-1:0]  sp_r;
  logic [SPW-1:0]  top_idx_s;

  assign top_idx_s = sp_r - SPW'(1);
  assign sp        = sp_r;
  assign full      = (sp_r == SPW'(DEPTH));
  assign empty     = (sp_r == SPW'(0));
  assign rd_data   = mem_r[rd_idx];

  // Stack pointer; push and pop are never requested together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_r <= '0;
    end else if (clr) begin
      sp_r <= '0;
    end else if (push && !full) begin
      sp_r <= sp_r + SPW'(1);
    end else if (pop && !empty) begin
      sp_r <= sp_r - SPW'(1);
    end else begin
      sp_r <= sp_r;
    end
  end

  // Entry storage: rewrite the top dir and push the new entry in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_top && !empty) begin
      mem_r[top_idx_s[AW-1:0]][2:0] <= top_dir;
    end
    if (push && !full) begin
      mem_r[sp_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/maze_dfs_solver.sv
// Depth-first maze solver from (0,0) to (N-1,N-1) over external wall memory,
// streaming the found path oldest-first over a valid/ready port.
module maze_dfs_solver
  import maze_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = N * N
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         mem_rd_en,
  output logic [2*$clog2(N)-1:0]       mem_addr,
  input  logic                         mem_rd_data,
  output logic                         path_valid,
  input  logic                         path_ready,
  output logic [$clog2(N)-1:0]         path_x,
  output logic [$clog2(N)-1:0]         path_y,
  output logic                         path_last,
  output logic [$clog2(DEPTH+1)-1:0]   path_len,
  output logic                         busy,
  output logic                         done,
  output logic                         fail
);

  localparam int CW  = $clog2(N);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int EW  = 2 * CW + 3;

  state_e          state_r, state_s;
  coord_t          cur_r, nb_s;
  logic [2:0]      dir_r;
  logic [N*N-1:0]  visited_r;
  logic [AW-1:0]   ri_r, rd_idx_s;
  logic [SPW-1:0]  path_len_r, sp_s;
  logic [EW-1:0]   push_data_s, rd_data_s;
  logic [2*CW-1:0] nb_addr_s;
  logic            push_s, pop_s, wr_top_s, clr_s, full_s, empty_s;
  logic            at_goal_s, nb_oob_s, nb_vis_s, try_s, last_s;

  maze_path_stack #(.CW(CW), .DEPTH(DEPTH), .SPW(SPW), .AW(AW)) u_stack (
    .clk(clk), .rst(rst), .clr(clr_s), .push(push_s), .pop(pop_s), .wr_top(wr_top_s),
    .push_data(push_data_s), .top_dir(dir_r + 3'd1), .rd_idx(rd_idx_s),
    .rd_data(rd_data_s), .sp(sp_s), .full(full_s), .empty(empty_s)
  );

  // Neighbour in the current direction; off-edge steps overflow past N-1.
  always_comb begin
    nb_s = cur_r;
    case (dir_e'(dir_r[1:0]))
      DIR_RIGHT: nb_s.x = cur_r.x + MAX_CW'(1);
      DIR_DOWN:  nb_s.y = cur_r.y + MAX_CW'(1);
      DIR_LEFT:  nb_s.x = cur_r.x - MAX_CW'(1);
      DIR_UP:    nb_s.y = cur_r.y - MAX_CW'(1);
      default:   nb_s = cur_r;
    endcase
  end

  assign nb_oob_s  = (nb_s.x > MAX_CW'(N - 1)) || (nb_s.y > MAX_CW'(N - 1));
  assign nb_addr_s = {nb_s.y[CW-1:0], nb_s.x[CW-1:0]};
  assign nb_vis_s  = visited_r[nb_addr_s];
  assign at_goal_s = (cur_r.x == MAX_CW'(N - 1)) && (cur_r.y == MAX_CW'(N - 1));
  assign try_s     = !at_goal_s && !dir_r[2] && !nb_oob_s && !nb_vis_s;
  assign last_s    = (SPW'(ri_r) == path_len_r - SPW'(1));
  assign path_len  = path_len_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_FAIL: if (start) state_s = S_INIT; else state_s = state_r;
      S_INIT:   state_s = S_INITW;
      S_INITW:  if (mem_rd_data) state_s = S_FAIL; else state_s = S_CHECK;
      S_CHECK: begin
        if (at_goal_s)                   state_s = S_REPLAY;
        else if (dir_r[2])               state_s = S_BACK;
        else if (nb_oob_s || nb_vis_s)   state_s = S_CHECK;
        else                             state_s = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_data)  state_s = S_CHECK;
        else if (full_s)  state_s = S_FAIL;
        else              state_s = S_CHECK;
      end
      S_BACK:   if (sp_s == SPW'(1)) state_s = S_FAIL; else state_s = S_CHECK;
      S_REPLAY: if (path_ready && last_s) state_s = S_DONE; else state_s = S_REPLAY;
      default:  state_s = S_IDLE;
    endcase
  end

  // Outputs and stack control decoded from the current state.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    wr_top_s    = 1'b0;
    clr_s       = 1'b0;
    push_data_s = {nb_addr_s, 3'd0};
    rd_idx_s    = ri_r;
    busy        = 1'b1;
    done        = 1'b0;
    fail        = 1'b0;
    path_valid  = 1'b0;
    path_last   = 1'b0;
    path_x      = '0;
    path_y      = '0;
    case (state_r)
      S_IDLE: busy = 1'b0;
      S_DONE: begin busy = 1'b0; done = 1'b1; end
      S_FAIL: begin busy = 1'b0; fail = 1'b1; end
      S_INIT: begin mem_rd_en = 1'b1; clr_s = 1'b1; end
      S_INITW: begin
        if (!mem_rd_data) begin push_s = 1'b1; push_data_s = '0; end
        else              push_s = 1'b0;
      end
      S_CHECK: begin
        if (try_s) begin mem_rd_en = 1'b1; mem_addr = nb_addr_s; end
        else       mem_rd_en = 1'b0;
      end
      S_WAIT: begin
        if (!mem_rd_data && !full_s) begin push_s = 1'b1; wr_top_s = !empty_s; end
        else                         push_s = 1'b0;
      end
      S_BACK: begin pop_s = 1'b1; rd_idx_s = sp_s[AW-1:0] - AW'(2); end
      S_REPLAY: begin
        path_valid = 1'b1;
        path_last  = last_s;
        path_y     = rd_data_s[EW-1 -: CW];
        path_x     = rd_data_s[EW-CW-1 -: CW];
      end
      default: busy = 1'b0;
    endcase
  end

  // Search datapath: position, direction, visited bitmap, replay index, path length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_r <= '0; dir_r <= '0; visited_r <= '0; ri_r <= '0; path_len_r <= '0;
    end else begin
      case (state_r)
        S_INIT: begin
          cur_r <= '0; dir_r <= '0; visited_r <= '0; ri_r <= '0; path_len_r <= '0;
        end
        S_INITW: if (!mem_rd_data) visited_r <= {{(N*N-1){1'b0}}, 1'b1};
        S_CHECK: begin
          if (at_goal_s) begin
            path_len_r <= sp_s;
            ri_r       <= '0;
          end else if (!dir_r[2] && (nb_oob_s || nb_vis_s)) begin
            dir_r <= dir_r + 3'd1;
          end
        end
        S_WAIT: begin
          if (mem_rd_data) begin
            dir_r <= dir_r + 3'd1;
          end else if (!full_s) begin
            visited_r[nb_addr_s] <= 1'b1;
            cur_r <= nb_s;
            dir_r <= 3'd0;
          end
        end
        S_BACK: begin
          if (sp_s != SPW'(1)) begin
            cur_r.y <= MAX_CW'(rd_data_s[EW-1 -: CW]);
            cur_r.x <= MAX_CW'(rd_data_s[EW-CW-1 -: CW]);
            dir_r   <= rd_data_s[2:0];
          end
        end
        S_REPLAY: if (path_ready && !last_s) ri_r <= ri_r + AW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/maze_dfs_solver.md
Name: maze_dfs_solver

Overview:
- Parametrised successor to the fixed-size maze-walking controller.
- Merges the FSM and its datapath into one block:
  - current-position registers,
  - direction counter,
  - path stack with a stored direction per entry,
  - visited bitmap,
  - replay streamer.
- Solves an N x N maze held in external wall memory by depth-first search from (0,0) to (N-1,N-1).
- On success it streams the found path out over a valid/ready port; on failure it flags fail.

Parameters:
- N, 8: maze side length in cells, power of two, 2..64.
- DEPTH, N*N: path stack entries; must be at least 2.
- Derived localparams:
  - CW = $clog2(N);
  - SPW = $clog2(DEPTH+1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin solve; sampled only in IDLE, DONE or FAIL.
- mem_rd_en  output  1  wall-memory read strobe.
- mem_addr  output  2*CW  cell address {y,x}.
- mem_rd_data  input  1  1 = wall; valid exactly one cycle after mem_rd_en.
- path_valid  output  1  path beat valid.
- path_ready  input  1  consumer accepts beat.
- path_x  output  CW  beat x coordinate.
- path_y  output  CW  beat y coordinate.
- path_last  output  1  final beat (goal cell).
- path_len  output  SPW  number of cells on the found path; 0 on fail.
- busy  output  1  high in every state except IDLE, DONE and FAIL.
- done  output  1  level; high in DONE.
- fail  output  1  level; high in FAIL.

Behaviour:
- Reset: state IDLE. All outputs 0, stack pointer 0, visited bitmap cleared, position (0,0), direction 0.
- Direction code:
  - 0 = x+1, 1 = y+1, 2 = x-1, 3 = y-1.
  - Tried in ascending order; a count of 4 means exhausted.
- Stack entry format: {y, x, dir}, where dir is the next direction still to try from that cell.
- States and transitions:
  - IDLE/DONE/FAIL: start=1 -> INIT. On leaving DONE or FAIL, done/fail clear.
  - INIT: clear visited, sp=0, cur=(0,0), dir=0; issue read of (0,0) -> INITW.
  - INITW:
    - wall -> FAIL;
    - else push {(0,0), 0}, mark visited -> CHECK.
  - CHECK (evaluated in this order):
    - cur == goal -> latch path_len = sp -> REPLAY;
    - dir == 4 -> BACK;
    - neighbour out of range (no wrap-around) or already visited -> dir++, stay in CHECK;
    - otherwise assert mem_rd_en with the neighbour address -> WAIT.
  - WAIT:
    - wall -> dir++ -> CHECK;
    - else if sp == DEPTH -> FAIL;
    - else write dir+1 into the top entry, push {neighbour, 0}, mark visited, cur = neighbour, dir = 0 -> CHECK.
  - BACK:
    - pop;
    - if sp becomes 0 -> FAIL;
    - else cur = new top coordinates, dir = its stored dir -> CHECK.
  - REPLAY:
    - index i counts from 0 to sp-1; present entry i with path_valid=1;
    - path_last = (i == sp-1);
    - i advances only on path_valid & path_ready;
    - coordinates are held stable while stalled;
    - the handshake on the last beat -> DONE.
- The stack is not popped during replay; the path is presented oldest first.
- start while busy: ignored.
- Reset asserted mid-operation returns the block to the reset state immediately; no partial path is emitted.
- Cells already visited are never re-entered, so every cell is pushed at most once and DEPTH = N*N never overflows. The overflow check matters only for smaller DEPTH.
- mem_rd_en is a single-cycle pulse. At most one read is outstanding; no new read is issued in WAIT.
- fail asserts with path_len = 0.

Decomposition:
- Shared package maze_pkg holds:
  - the direction enum (DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_UP);
  - the state enum;
  - the coordinate struct {y, x}.
- One natural sub-module, maze_path_stack: parametrised LIFO supporting
  - push/pop,
  - top-entry dir rewrite,
  - indexed read port for replay,
  - full/empty flags.
- The visited bitmap and the FSM stay in the top level.

Test Plan:
- N=4, no walls, start pulse, path_ready=1 -> beats (0,0),(1,0),(2,0),(3,0),(3,1),(3,2),(3,3); path_last only on (3,3); path_len=7; done=1; fail=0.
- N=4, walls at (2,3) and (3,2) -> all reachable cells explored, then fail=1, path_len=0, no path_valid ever.
- N=4, wall at (0,0) -> fail=1 within 3 cycles of start; exactly one mem_rd_en seen.
- N=4, dead-end corridor (walls force x+1 to (3,0), then a dead end) -> BACK pops observed; final path excludes dead-end cells; path_len=7 via the lower route.
- Replay backpressure: path_ready toggling 1,0,0,1 -> each beat held while stalled; no beat duplicated or dropped; done only after the last handshake.
- rst pulsed mid-search, then a fresh start on the open maze -> the complete 7-beat path is emitted again. Also with N=4, DEPTH=3 on the open maze -> fail=1.
